logic_reduce: RTL and testbench

//  Parametrised, clocked successor to the combinational bitwise gates.
//  - Accepts a stream of WIDTH-bit words grouped into packets; each packet ends with in_last.
//  - Folds each packet into one word with a selected bitwise op (AND/OR/XOR/XNOR).
//  - Presents the result on a valid/ready output port.
//  - Used wherever a multi-word mask or parity word must be built from sequential data.

---
 rtl/logic_reduce.sv | 74 +++++++
 tb/tb_logic_reduce.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/logic_reduce.sv
// logic_reduce: folds each in_last-terminated packet of WIDTH-bit words with AND/OR/XOR/XNOR onto a valid/ready output.
// Define LOGIC_REDUCE_CNT_EN to add the CNT_W parameter and the saturating out_count beat counter.
module logic_reduce #(
    parameter int WIDTH = 16
`ifdef LOGIC_REDUCE_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef LOGIC_REDUCE_CNT_EN
    , output logic [CNT_W-1:0] out_count
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d, fold;
    logic [1:0] op_q, op_d;
    logic accept, first;
    assign in_ready = ~reset & ((state_q != DONE) | out_ready);
    assign accept = in_valid & in_ready;
    // an accept in DONE implies out_ready, so it starts a new packet like IDLE
    assign first = state_q != ACCUM;
    assign out_valid = state_q == DONE;
    assign out_data = res_q;
    always_comb begin
        fold = op_q == 2'b00 ? acc_q & in_data :
               op_q == 2'b01 ? acc_q | in_data :
               op_q == 2'b10 ? acc_q ^ in_data : ~(acc_q ^ in_data);
        acc_d = accept ? (first ? in_data : fold) : acc_q;
        op_d = accept & first ? op : op_q;
        res_d = accept & in_last ? acc_d : res_q;
        state_d = accept ? (in_last ? DONE : ACCUM) :
                  (state_q == DONE && out_ready) ? IDLE : state_q;
    end
`ifdef LOGIC_REDUCE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
    assign out_count = ocnt_q;
    always_comb begin
        cnt_d = accept ? (first ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1)) : cnt_q;
        ocnt_d = accept & in_last ? cnt_d : ocnt_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ocnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ocnt_q <= ocnt_d;
        end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q <= '0;
            res_q <= '0;
            op_q <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            res_q <= res_d;
            op_q <= op_d;
        end
    end
endmodule

// File: tb/tb_logic_reduce.sv
// tb_logic_reduce: directed and random packets checked cycle by cycle against a packet-list reference model.
module tb_logic_reduce;
    localparam int W = 16;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0] op;
`ifdef LOGIC_REDUCE_CNT_EN
    logic [CW-1:0] out_count;
`endif
    always #5 clk = ~clk;

    logic_reduce #(
        .WIDTH(W)
`ifdef LOGIC_REDUCE_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .op(op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef LOGIC_REDUCE_CNT_EN
        , .out_count(out_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic pending = 1'b0;
    logic [W-1:0] exp_data = '0;
    int exp_cnt = 0;
    logic [W-1:0] pkt[$];
    logic [1:0] pkt_op = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // per bit: count the ones across the whole packet and apply the op's meaning
    function automatic logic [W-1:0] reduce_pkt();
        logic [W-1:0] r;
        int k;
        k = pkt.size();
        for (int b = 0; b < W; b++) begin
            int n;
            n = 0;
            foreach (pkt[i]) n += int'(pkt[i][b]);
            case (pkt_op)
                2'b00: r[b] = (n == k);
                2'b01: r[b] = (n > 0);
                2'b10: r[b] = n[0];
                default: r[b] = ((n + k - 1) % 2) == 1;
            endcase
        end
        return r;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(pending));
        chk({tag, ".out_data"}, 32'(out_data), 32'(exp_data));
`ifdef LOGIC_REDUCE_CNT_EN
        chk({tag, ".out_count"}, 32'(out_count), 32'(exp_cnt));
`endif
    endtask

    task automatic cycle(input string tag, input logic v, input logic [W-1:0] d, input logic l,
                         input logic [1:0] o, input logic r);
        logic acc, comp;
        in_valid = v; in_data = d; in_last = l; op = o; out_ready = r;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!pending || r));
        acc = v && (!pending || r);
        comp = pending && r;
        if (comp) pending = 1'b0;
        if (acc) begin
            if (pkt.size() == 0) pkt_op = o;
            pkt.push_back(d);
            if (l) begin
                exp_data = reduce_pkt();
                exp_cnt = pkt.size() > 255 ? 255 : pkt.size();
                pending = 1'b1;
                pkt.delete();
            end
        end
        @(posedge clk);
        #1;
        check_outs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = '0; op = 2'b00; out_ready = 1'b1;
        #1;
        pending = 1'b0; exp_data = '0; exp_cnt = 0; pkt.delete();
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        check_outs("reset");
        repeat (n) @(negedge clk);
        chk("reset_hold.in_ready", 32'(in_ready), 32'd0);
        check_outs("reset_hold");
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; op = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        do_reset(3);
        cycle("and0", 1, 16'h0000, 0, 2'b00, 1);
        cycle("and1", 1, 16'hFFFF, 1, 2'b00, 0);
        chk("t1.and_result", 32'(out_data), 32'h0000);
        cycle("xor0", 1, 16'hAAAA, 0, 2'b10, 1);
        cycle("xor1", 1, 16'h5555, 1, 2'b01, 0);
        chk("t2.xor_result", 32'(out_data), 32'hFFFF);
        cycle("or0", 1, 16'h1234, 0, 2'b01, 1);
        cycle("or1", 1, 16'h9876, 0, 2'b00, 1);
        cycle("or2", 1, 16'h0001, 1, 2'b11, 0);
        chk("t2.or_result", 32'(out_data), 32'h9A77);
        cycle("xnor0", 1, 16'h3CC3, 0, 2'b11, 1);
        cycle("xnor1", 1, 16'h0FF0, 1, 2'b11, 1);
        chk("t3.xnor_result", 32'(out_data), 32'hCCCC);
        cycle("single", 1, 16'h1234, 1, 2'b00, 1);
        chk("t3.single_result", 32'(out_data), 32'h1234);
        for (int i = 0; i < 5; i++) cycle("stall", 1, 16'hDEAD, 1, 2'b01, 0);
        chk("t4.stall_data", 32'(out_data), 32'h1234);
        cycle("b2b", 1, 16'h00F0, 0, 2'b01, 1);
        cycle("b2b_last", 1, 16'h0F00, 1, 2'b10, 1);
        chk("t4.b2b_result", 32'(out_data), 32'h0FF0);
        cycle("drain", 0, 16'h0, 0, 2'b00, 1);
        cycle("abort0", 1, 16'h0101, 0, 2'b01, 1);
        cycle("abort1", 1, 16'h1010, 0, 2'b01, 1);
        do_reset(1);
        cycle("post_rst", 0, 16'h0, 0, 2'b00, 1);
        cycle("fresh", 1, 16'hFFFF, 1, 2'b00, 0);
        chk("t5.fresh_result", 32'(out_data), 32'hFFFF);
        cycle("drain2", 0, 16'h0, 0, 2'b00, 1);
`ifdef LOGIC_REDUCE_CNT_EN
        for (int i = 0; i < 299; i++) cycle("long", 1, 16'(i), 0, 2'b10, 1);
        cycle("long_last", 1, 16'h5A5A, 1, 2'b10, 1);
        chk("t6.sat_count", 32'(out_count), 32'd255);
        cycle("c3a", 1, 16'h1, 0, 2'b01, 1);
        cycle("c3b", 1, 16'h2, 0, 2'b01, 1);
        cycle("c3c", 1, 16'h4, 1, 2'b01, 0);
        chk("t6.count3", 32'(out_count), 32'd3);
        cycle("drain3", 0, 16'h0, 0, 2'b00, 1);
`endif
        for (int i = 0; i < 600; i++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                  2'($urandom), 1'($urandom_range(0, 3) != 0));
        cycle("final", 0, 16'h0, 0, 2'b00, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
